warp_thread_scoreboard: RTL and testbench
=========================================

Name: warp_thread_scoreboard

Overview:
- Per-thread busy scoreboard for the compute unit; produces the `busy_threads` vector consumed by the warp readiness checker.
- The scheduler issues instructions into it. It marks the issuing warp's active threads busy and releases them on one of two events:
  - automatically after a fixed latency (ALU/tensor ops);
  - on an explicit completion from the variable-latency path (memory/writeback).
- It also gates issue so that no thread is ever double-booked.

Parameters:
- NUM_THREADS, 32, total threads. Fixed at 4 warps, so THREADS_PER_WARP = NUM_THREADS/4 = 8.
- FIX_LAT, 4, cycles a fixed-latency op holds its threads busy. Legal range is 1 or more.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- iss_valid  in  1  scheduler presents an issue
- iss_ready  out  1  issue can be accepted this cycle
- iss_warp  in  2  warp index of the issue
- iss_threads  in  8  decoded active-thread mask of the issue (Threads_Mask_Decoder output)
- iss_fixed  in  1  1 = fixed-latency op (auto-release); 0 = variable-latency (released by completion)
- cmp_valid  in  1  variable-latency completion
- cmp_warp  in  2  warp of the completion
- cmp_threads  in  8  threads completing
- flush  in  1  synchronous clear of all scoreboard state
- busy_threads  out  NUM_THREADS  registered busy vector. Warp w occupies bits [NUM_THREADS-1-8w -: 8], so warp 0 is the MSB byte.
- idle  out  1  no busy bits and no fixed op in flight
- cmp_err  out  1  sticky: a completion targeted threads that were not variable-busy

Behaviour:
- Reset (async, rst_n=0): busy_threads=0, fixed-owner register=0, delay line empty, cmp_err=0. Therefore idle=1 and iss_ready=1.
- State:
  - busy register (NUM_THREADS);
  - fix_own register (NUM_THREADS), where 1 means the bit is held by a fixed op;
  - FIX_LAT-stage delay line of {v, warp[1:0], threads[7:0]}.
- iss_ready is combinational: iss_ready = ~flush & ~|(busy slice[iss_warp] & iss_threads). It uses the registered busy value only.
- Accept occurs when iss_valid & iss_ready. At the next edge:
  - the iss_threads bits of the warp slice are set in busy;
  - fix_own bits are set to iss_fixed.
- Fixed ops:
  - An accepted fixed op enters stage 0 of the delay line. The line advances one stage per cycle.
  - When the op leaves the last stage, its threads are cleared in busy and fix_own.
  - Net effect: bits are visible busy for exactly FIX_LAT cycles (accept at edge N, busy in cycles N+1 .. N+FIX_LAT, clear at edge N+FIX_LAT).
- Completion (cmp_valid):
  - Let E be the subset of cmp_threads that is busy and not fix_own. The E bits are cleared at the next edge.
  - Any bit in cmp_threads outside E is ignored and sets cmp_err (sticky until reset).
- Next-state equation: busy_next = (busy & ~fix_release & ~cmp_clear) | iss_set.
  - Set and clear can never hit the same bit in one cycle, because iss_ready compares against the registered busy, and bits releasing this cycle still read busy.
  - A second issue to the same threads is therefore accepted one cycle after release at the earliest.
- Zero mask issue (iss_threads=0):
  - Always accepted and changes no busy bits.
  - A fixed one still occupies a delay-line slot and holds idle low for FIX_LAT cycles.
- A fixed release and a completion in the same cycle, on different warps or different bits, both take effect.
- flush=1:
  - iss_ready=0 and no accept occurs.
  - At the next edge, busy, fix_own and the delay line clear.
  - cmp_err holds its value.
  - A completion in the flush cycle is ignored and raises no error.
- idle = (busy==0) & (no valid stage in the delay line).
- Reset asserted mid-operation clears everything immediately. No release events are generated.

Test Plan:
- Reset, then a fixed issue to warp 1 with threads 0xF0, FIX_LAT=4, accepted at edge 0 -> busy_threads[23:16]=0xF0 in cycles 1-4, 0x00 from cycle 5; idle=0 in cycles 1-4 and 1 in cycle 5.
- Variable issue to warp 0 with 0x0F; then issue to warp 0 with 0x01 -> iss_ready=0. Issue to warp 0 with 0x10 -> accepted, busy[31:24]=0x1F. cmp warp 0 with 0x0F -> busy[31:24]=0x10 next cycle, cmp_err=0.
- Completion to warp 2 with 0x01 while nothing is busy -> busy unchanged, cmp_err=1 and stays 1 through later traffic. Completion targeting fixed-held bits -> bits stay busy, cmp_err=1.
- Fixed op on warp 3 with 0xFF releasing at edge K, plus iss_valid to warp 3 with 0x01 in cycle K -> rejected in cycle K, accepted in cycle K+1. In the same cycle K, cmp on warp 0 clears its bits.
- Busy state on all four warps, then flush=1 for one cycle -> iss_ready=0 during that cycle, busy_threads=0 and idle=1 after the edge, cmp_err retained.
- rst_n pulled low asynchronously mid-pipeline with 3 fixed ops in flight -> all outputs return to their reset values without waiting for a clock. No stale release occurs after rst_n rises.

Source files
------------

// File: rtl/warp_thread_scoreboard.sv
// Per-thread busy scoreboard: marks issued threads busy, releases them after a
// fixed latency or on an explicit completion, and blocks double-booking at issue.
module warp_thread_scoreboard #(
    parameter int unsigned NUM_THREADS = 32,
    parameter int unsigned FIX_LAT     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iss_valid,
    output logic                     iss_ready,
    input  logic [1:0]               iss_warp,
    input  logic [NUM_THREADS/4-1:0] iss_threads,
    input  logic                     iss_fixed,
    input  logic                     cmp_valid,
    input  logic [1:0]               cmp_warp,
    input  logic [NUM_THREADS/4-1:0] cmp_threads,
    input  logic                     flush,
    output logic [NUM_THREADS-1:0]   busy_threads,
    output logic                     idle,
    output logic                     cmp_err
);

    localparam int unsigned TPW  = NUM_THREADS / 4;
    localparam int unsigned LAST = FIX_LAT - 1;

    logic [NUM_THREADS-1:0] r_busy;
    logic [NUM_THREADS-1:0] r_fix_own;
    logic                   r_cmp_err;
    logic [FIX_LAT-1:0]     r_dl_v;
    logic [1:0]             r_dl_warp [FIX_LAT];
    logic [TPW-1:0]         r_dl_thr  [FIX_LAT];

    logic [TPW-1:0]         w_busy_w  [4];
    logic [TPW-1:0]         w_own_w   [4];
    logic [NUM_THREADS-1:0] w_iss_set;
    logic [NUM_THREADS-1:0] w_cmp_clr;
    logic [NUM_THREADS-1:0] w_fix_rel;
    logic [TPW-1:0]         w_cmp_ok;
    logic                   w_accept;
    logic                   w_cmp_bad;

    // Per-warp views; warp 0 occupies the most significant slice.
    for (genvar g = 0; g < 4; g++) begin : g_warp
        localparam int unsigned LO = TPW * (3 - g);
        assign w_busy_w[g] = r_busy[LO +: TPW];
        assign w_own_w[g]  = r_fix_own[LO +: TPW];
        assign w_iss_set[LO +: TPW] = (w_accept && iss_warp == 2'(g)) ? iss_threads : '0;
        assign w_cmp_clr[LO +: TPW] = (cmp_valid && !flush && cmp_warp == 2'(g))
                                      ? (cmp_threads & w_busy_w[g] & ~w_own_w[g]) : '0;
        assign w_fix_rel[LO +: TPW] = (r_dl_v[LAST] && r_dl_warp[LAST] == 2'(g))
                                      ? r_dl_thr[LAST] : '0;
    end

    // Ready compares against registered busy only, so set and clear never collide.
    assign iss_ready = ~flush & ~|(w_busy_w[iss_warp] & iss_threads);
    assign w_accept  = iss_valid & iss_ready;
    assign w_cmp_ok  = w_busy_w[cmp_warp] & ~w_own_w[cmp_warp];
    assign w_cmp_bad = cmp_valid & ~flush & |(cmp_threads & ~w_cmp_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= '0;
            r_fix_own <= '0;
            r_cmp_err <= 1'b0;
        end else if (flush) begin
            r_busy    <= '0;
            r_fix_own <= '0;
        end else begin
            r_busy    <= (r_busy & ~w_fix_rel & ~w_cmp_clr) | w_iss_set;
            r_fix_own <= (r_fix_own & ~w_fix_rel & ~w_iss_set)
                         | (iss_fixed ? w_iss_set : '0);
            if (w_cmp_bad) begin
                r_cmp_err <= 1'b1;
            end
        end
    end

    // Fixed-latency delay line; a zero-mask fixed op still occupies a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_v[0]    <= 1'b0;
            r_dl_warp[0] <= '0;
            r_dl_thr[0]  <= '0;
        end else begin
            r_dl_v[0]    <= w_accept & iss_fixed;
            r_dl_warp[0] <= iss_warp;
            r_dl_thr[0]  <= iss_threads;
        end
    end

    for (genvar s = 1; s < FIX_LAT; s++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dl_v[s]    <= 1'b0;
                r_dl_warp[s] <= '0;
                r_dl_thr[s]  <= '0;
            end else begin
                r_dl_v[s]    <= r_dl_v[s-1] & ~flush;
                r_dl_warp[s] <= r_dl_warp[s-1];
                r_dl_thr[s]  <= r_dl_thr[s-1];
            end
        end
    end

    assign busy_threads = r_busy;
    assign cmp_err      = r_cmp_err;
    assign idle         = ~|r_busy & ~|r_dl_v;

endmodule

// File: tb/tb_warp_thread_scoreboard.sv
// Directed bench for warp_thread_scoreboard with hand-computed expectations.
module tb_warp_thread_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        iss_valid;
    logic        iss_ready;
    logic [1:0]  iss_warp;
    logic [7:0]  iss_threads;
    logic        iss_fixed;
    logic        cmp_valid;
    logic [1:0]  cmp_warp;
    logic [7:0]  cmp_threads;
    logic        flush;
    logic [31:0] busy_threads;
    logic        idle;
    logic        cmp_err;

    int n_checks;
    int n_fail;

    warp_thread_scoreboard #(.NUM_THREADS(32), .FIX_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_warp(iss_warp),
        .iss_threads(iss_threads), .iss_fixed(iss_fixed),
        .cmp_valid(cmp_valid), .cmp_warp(cmp_warp), .cmp_threads(cmp_threads),
        .flush(flush), .busy_threads(busy_threads), .idle(idle), .cmp_err(cmp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        iss_valid = 1'b0; iss_warp = 2'd0; iss_threads = 8'h00; iss_fixed = 1'b0;
        cmp_valid = 1'b0; cmp_warp = 2'd0; cmp_threads = 8'h00; flush = 1'b0;
    endtask

    task automatic issue(input logic [1:0] w, input logic [7:0] t, input logic fx);
        iss_valid = 1'b1; iss_warp = w; iss_threads = t; iss_fixed = fx;
    endtask

    task automatic test_reset;
        quiet();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (busy_threads !== 32'h0 || idle !== 1'b1 || iss_ready !== 1'b1 || cmp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: busy=%h idle=%b ready=%b err=%b, want 0/1/1/0",
                     busy_threads, idle, iss_ready, cmp_err);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fixed_latency;
        logic [7:0] exp_b;
        issue(2'd1, 8'hF0, 1'b1);
        #1;
        n_checks++;
        if (iss_ready !== 1'b1) begin
            n_fail++; $display("FAIL fixed_ready: got %b want 1", iss_ready);
        end
        tick();
        quiet();
        n_checks++;
        if (busy_threads !== 32'h00F0_0000) begin
            n_fail++; $display("FAIL fixed_vector: got %h want 00f00000", busy_threads);
        end
        for (int c = 1; c <= 5; c++) begin
            exp_b = (c <= 4) ? 8'hF0 : 8'h00;
            n_checks++;
            if (busy_threads[23:16] !== exp_b || idle !== (c > 4)) begin
                n_fail++;
                $display("FAIL fixed_cycle%0d: busy=%h idle=%b, want %h/%b",
                         c, busy_threads[23:16], idle, exp_b, (c > 4));
            end
            tick();
        end
    endtask

    task automatic test_variable;
        issue(2'd0, 8'h0F, 1'b0);
        tick();
        issue(2'd0, 8'h01, 1'b0);
        #1;
        n_checks++;
        if (iss_ready !== 1'b0) begin
            n_fail++; $display("FAIL var_conflict_ready: got %b want 0", iss_ready);
        end
        tick();
        n_checks++;
        if (busy_threads !== 32'h0F00_0000) begin
            n_fail++; $display("FAIL var_after_reject: got %h want 0f000000", busy_threads);
        end
        issue(2'd0, 8'h10, 1'b0);
        #1;
        n_checks++;
        if (iss_ready !== 1'b1) begin
            n_fail++; $display("FAIL var_disjoint_ready: got %b want 1", iss_ready);
        end
        tick();
        quiet();
        n_checks++;
        if (busy_threads !== 32'h1F00_0000) begin
            n_fail++; $display("FAIL var_merge: got %h want 1f000000", busy_threads);
        end
        cmp_valid = 1'b1; cmp_warp = 2'd0; cmp_threads = 8'h0F;
        tick();
        quiet();
        n_checks++;
        if (busy_threads !== 32'h1000_0000 || cmp_err !== 1'b0) begin
            n_fail++; $display("FAIL var_complete: busy=%h err=%b want 10000000/0", busy_threads, cmp_err);
        end
        cmp_valid = 1'b1; cmp_warp = 2'd0; cmp_threads = 8'h10;
        tick();
        quiet();
        n_checks++;
        if (busy_threads !== 32'h0 || idle !== 1'b1 || cmp_err !== 1'b0) begin
            n_fail++; $display("FAIL var_drain: busy=%h idle=%b err=%b want 0/1/0", busy_threads, idle, cmp_err);
        end
    endtask

    task automatic test_zero_mask;
        issue(2'd2, 8'h00, 1'b1);
        #1;
        n_checks++;
        if (iss_ready !== 1'b1) begin
            n_fail++; $display("FAIL zero_ready: got %b want 1", iss_ready);
        end
        tick();
        quiet();
        for (int c = 1; c <= 5; c++) begin
            n_checks++;
            if (busy_threads !== 32'h0 || idle !== (c > 4)) begin
                n_fail++;
                $display("FAIL zero_cycle%0d: busy=%h idle=%b want 0/%b", c, busy_threads, idle, (c > 4));
            end
            tick();
        end
    endtask

    task automatic test_cmp_err;
        cmp_valid = 1'b1; cmp_warp = 2'd2; cmp_threads = 8'h01;
        tick();
        quiet();
        n_checks++;
        if (busy_threads !== 32'h0 || cmp_err !== 1'b1) begin
            n_fail++; $display("FAIL err_idle_cmp: busy=%h err=%b want 0/1", busy_threads, cmp_err);
        end
        issue(2'd1, 8'h03, 1'b1);
        tick();
        quiet();
        cmp_valid = 1'b1; cmp_warp = 2'd1; cmp_threads = 8'h01;
        tick();
        quiet();
        n_checks++;
        if (busy_threads !== 32'h0003_0000 || cmp_err !== 1'b1) begin
            n_fail++; $display("FAIL err_fixed_cmp: busy=%h err=%b want 00030000/1", busy_threads, cmp_err);
        end
        tick(); tick(); tick();
        n_checks++;
        if (busy_threads !== 32'h0 || cmp_err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: busy=%h err=%b want 0/1", busy_threads, cmp_err);
        end
    endtask

    task automatic test_back_to_back;
        issue(2'd0, 8'h03, 1'b0);
        tick();
        issue(2'd3, 8'hFF, 1'b1);
        tick();
        quiet();
        tick(); tick(); tick();
        issue(2'd3, 8'h01, 1'b0);
        cmp_valid = 1'b1; cmp_warp = 2'd0; cmp_threads = 8'h03;
        #1;
        n_checks++;
        if (iss_ready !== 1'b0 || busy_threads !== 32'h0300_00FF) begin
            n_fail++; $display("FAIL b2b_release_cycle: ready=%b busy=%h want 0/030000ff", iss_ready, busy_threads);
        end
        tick();
        cmp_valid = 1'b0; cmp_threads = 8'h00;
        #1;
        n_checks++;
        if (iss_ready !== 1'b1 || busy_threads !== 32'h0) begin
            n_fail++; $display("FAIL b2b_next_cycle: ready=%b busy=%h want 1/00000000", iss_ready, busy_threads);
        end
        tick();
        quiet();
        n_checks++;
        if (busy_threads !== 32'h0000_0001) begin
            n_fail++; $display("FAIL b2b_reissue: got %h want 00000001", busy_threads);
        end
        cmp_valid = 1'b1; cmp_warp = 2'd3; cmp_threads = 8'h01;
        tick();
        quiet();
        n_checks++;
        if (busy_threads !== 32'h0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL b2b_drain: busy=%h idle=%b want 0/1", busy_threads, idle);
        end
    endtask

    task automatic test_flush;
        issue(2'd0, 8'h11, 1'b0); tick();
        issue(2'd1, 8'h22, 1'b0); tick();
        issue(2'd3, 8'h88, 1'b0); tick();
        issue(2'd2, 8'h44, 1'b1); tick();
        quiet();
        n_checks++;
        if (busy_threads !== 32'h1122_4488) begin
            n_fail++; $display("FAIL flush_setup: got %h want 11224488", busy_threads);
        end
        flush = 1'b1;
        issue(2'd0, 8'h02, 1'b0);
        cmp_valid = 1'b1; cmp_warp = 2'd0; cmp_threads = 8'h11;
        #1;
        n_checks++;
        if (iss_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_ready: got %b want 0", iss_ready);
        end
        tick();
        quiet();
        n_checks++;
        if (busy_threads !== 32'h0 || idle !== 1'b1 || cmp_err !== 1'b1) begin
            n_fail++; $display("FAIL flush_clear: busy=%h idle=%b err=%b want 0/1/1", busy_threads, idle, cmp_err);
        end
        tick(); tick(); tick(); tick();
        n_checks++;
        if (busy_threads !== 32'h0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL flush_settled: busy=%h idle=%b want 0/1", busy_threads, idle);
        end
    endtask

    task automatic test_async_reset;
        issue(2'd0, 8'h01, 1'b1); tick();
        issue(2'd1, 8'h01, 1'b1); tick();
        issue(2'd2, 8'hF0, 1'b1); tick();
        quiet();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy_threads !== 32'h0 || idle !== 1'b1 || iss_ready !== 1'b1 || cmp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%h idle=%b ready=%b err=%b want 0/1/1/0",
                     busy_threads, idle, iss_ready, cmp_err);
        end
        tick();
        rst_n = 1'b1;
        issue(2'd2, 8'hF0, 1'b0);
        tick();
        quiet();
        tick(); tick(); tick(); tick(); tick();
        n_checks++;
        if (busy_threads !== 32'h0000_F000 || idle !== 1'b0 || cmp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_no_stale: busy=%h idle=%b err=%b want 0000f000/0/0",
                     busy_threads, idle, cmp_err);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fixed_latency();
        test_variable();
        test_zero_mask();
        test_cmp_err();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
